// File: rtl/seven_seg_pkg.sv
// Shared types and segment patterns for the two-digit 7-segment capture block.
// Bus bit order is {g,f,e,d,c,b,a}, active-high.
package seven_seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'h3F;
    localparam seg7_t SEG_1     = 7'h06;
    localparam seg7_t SEG_2     = 7'h5B;
    localparam seg7_t SEG_3     = 7'h4F;
    localparam seg7_t SEG_4     = 7'h66;
    localparam seg7_t SEG_5     = 7'h6D;
    localparam seg7_t SEG_6     = 7'h7D;
    localparam seg7_t SEG_7     = 7'h07;
    localparam seg7_t SEG_8     = 7'h7F;
    localparam seg7_t SEG_9     = 7'h6F;
    localparam seg7_t SEG_A     = 7'h77;
    localparam seg7_t SEG_B     = 7'h7C;
    localparam seg7_t SEG_C     = 7'h39;
    localparam seg7_t SEG_D     = 7'h5E;
    localparam seg7_t SEG_E     = 7'h79;
    localparam seg7_t SEG_F     = 7'h71;
    localparam seg7_t SEG_BLANK = 7'h00;

    typedef enum logic {
        EXP_HI = 1'b0,
        EXP_LO = 1'b1
    } state_t;

endpackage

// File: rtl/seven_seg_capture_if.sv
// Segment link from the display driver: seg_in is valid in any cycle where seg_strobe=1
// (no ready; every strobe cycle is one digit). dbg_state exposes the capture FSM.
interface seven_seg_capture_if;
    import seven_seg_pkg::*;

    seg7_t  seg_in;
    logic   seg_strobe;
    state_t dbg_state;

    modport master (output seg_in, output seg_strobe, input dbg_state);
    modport slave  (input seg_in, input seg_strobe, output dbg_state);
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational 7-segment pattern to hex nibble decoder; unknown patterns give 0 with err set.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  seg7_t      pat,
    output logic       err,
    output logic [3:0] nib
);

    always_comb begin
        err = 1'b0;
        nib = 4'h0;
        case (pat)
            SEG_0:     nib = 4'h0;
            SEG_1:     nib = 4'h1;
            SEG_2:     nib = 4'h2;
            SEG_3:     nib = 4'h3;
            SEG_4:     nib = 4'h4;
            SEG_5:     nib = 4'h5;
            SEG_6:     nib = 4'h6;
            SEG_7:     nib = 4'h7;
            SEG_8:     nib = 4'h8;
            SEG_9:     nib = 4'h9;
            SEG_A:     nib = 4'hA;
            SEG_B:     nib = 4'hB;
            SEG_C:     nib = 4'hC;
            SEG_D:     nib = 4'hD;
            SEG_E:     nib = 4'hE;
            SEG_F:     nib = 4'hF;
            SEG_BLANK: err = 1'b1;
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed two-digit 7-segment link: demux, decode, publish, stall watchdog.
// Optional strobe-period checker enabled by defining SEVEN_SEG_PERIOD_CHECK_EN.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int PERIOD  = 12501,
    parameter int TIMEOUT = 16384,
    parameter int CBITS   = 15
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_capture_if.slave  link,
    output logic [3:0]          digit_hi,
    output logic [3:0]          digit_lo,
    output logic                frame_valid,
    output logic                frame_err,
    output logic                stall,
    output logic                period_err
);

    localparam logic [CBITS-1:0] CNT_MAX = CBITS'(TIMEOUT);
    localparam logic [CBITS-1:0] CNT_PRE = CBITS'(TIMEOUT - 1);

    if (TIMEOUT <= PERIOD || TIMEOUT >= (1 << CBITS)) begin : g_cfg_bad
        $error("seven_seg_capture: need PERIOD < TIMEOUT < 2**CBITS");
    end

    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [3:0]       hi_nib_q, hi_nib_d;
    logic             hi_err_q, hi_err_d;
    logic [3:0]       digit_hi_q, digit_hi_d;
    logic [3:0]       digit_lo_q, digit_lo_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             stall_q, stall_d;
    logic             dec_err;
    logic [3:0]       dec_nib;
    logic             timeout_hit;

    seven_seg_decode u_decode (
        .pat (link.seg_in),
        .err (dec_err),
        .nib (dec_nib)
    );

    // A strobe in the would-be timeout cycle wins, so the watchdog only fires on a quiet cycle.
    assign timeout_hit = !link.seg_strobe && (cnt_q == CNT_PRE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_nib_d      = hi_nib_q;
        hi_err_d      = hi_err_q;
        digit_hi_d    = digit_hi_q;
        digit_lo_d    = digit_lo_q;
        frame_valid_d = 1'b0;
        frame_err_d   = frame_err_q;
        stall_d       = stall_q;
        if (link.seg_strobe) begin
            cnt_d   = '0;
            stall_d = 1'b0;
            case (state_q)
                EXP_HI: begin
                    hi_nib_d = dec_nib;
                    hi_err_d = dec_err;
                    state_d  = EXP_LO;
                end
                EXP_LO: begin
                    digit_hi_d    = hi_nib_q;
                    digit_lo_d    = dec_nib;
                    frame_err_d   = hi_err_q | dec_err;
                    frame_valid_d = 1'b1;
                    state_d       = EXP_HI;
                end
                default: state_d = EXP_HI;
            endcase
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CBITS'(1);
            if (timeout_hit) begin
                stall_d  = 1'b1;
                state_d  = EXP_HI;
                hi_nib_d = 4'h0;
                hi_err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EXP_HI;
            cnt_q         <= '0;
            hi_nib_q      <= 4'h0;
            hi_err_q      <= 1'b0;
            digit_hi_q    <= 4'h0;
            digit_lo_q    <= 4'h0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_nib_q      <= hi_nib_d;
            hi_err_q      <= hi_err_d;
            digit_hi_q    <= digit_hi_d;
            digit_lo_q    <= digit_lo_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            stall_q       <= stall_d;
        end
    end

`ifdef SEVEN_SEG_PERIOD_CHECK_EN
    logic first_q, first_d;
    logic period_err_q, period_err_d;

    // The first strobe after reset or a stall has no meaningful predecessor to measure from.
    always_comb begin
        first_d      = first_q;
        period_err_d = period_err_q;
        if (link.seg_strobe) begin
            if (!first_q && ((CBITS+1)'(cnt_q) + (CBITS+1)'(1) != (CBITS+1)'(PERIOD)))
                period_err_d = 1'b1;
            first_d = 1'b0;
        end else if (timeout_hit) begin
            first_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q      <= 1'b1;
            period_err_q <= 1'b0;
        end else begin
            first_q      <= first_d;
            period_err_q <= period_err_d;
        end
    end

    assign period_err = period_err_q;
`else
    assign period_err = 1'b0;
`endif

    assign link.dbg_state = state_q;
    assign digit_hi       = digit_hi_q;
    assign digit_lo       = digit_lo_q;
    assign frame_valid    = frame_valid_q;
    assign frame_err      = frame_err_q;
    assign stall          = stall_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: timestamp-based reference model, frame scoreboard, per-cycle compare.
module tb_seven_seg_capture;
  import seven_seg_pkg::*;

  localparam int P  = 101;
  localparam int T  = 160;
  localparam int CB = 8;
`ifdef SEVEN_SEG_PERIOD_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_seg_capture_if li ();
  logic [3:0] digit_hi, digit_lo;
  logic       frame_valid, frame_err, stall, period_err;

  seven_seg_capture #(.PERIOD(P), .TIMEOUT(T), .CBITS(CB)) dut (
    .clk         (clk),
    .rst         (rst),
    .link        (li.slave),
    .digit_hi    (digit_hi),
    .digit_lo    (digit_lo),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .stall       (stall),
    .period_err  (period_err)
  );

  int tests = 0;
  int fails = 0;
  int since = 0;
  bit chk_en = 1'b0;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_dec(logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (tbl[i] == p) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  // ---------------- reference model ----------------
  int         cyc = 0, anchor = 0, last_stb = 0;
  bit         m_first = 1'b1, m_have_hi = 1'b0;
  logic [6:0] m_hi_pat = '0;
  logic [3:0] m_hi = '0, m_lo = '0;
  logic       m_err = 1'b0, m_fv = 1'b0, m_stall = 1'b0, m_perr = 1'b0;
  logic [8:0] exp_q [$];

  always @(posedge clk) begin
    logic [4:0] dh, dl;
    cyc++;
    if (rst) begin
      anchor = cyc; m_first = 1'b1; m_have_hi = 1'b0; m_hi_pat = '0;
      m_hi = '0; m_lo = '0; m_err = 1'b0; m_fv = 1'b0; m_stall = 1'b0; m_perr = 1'b0;
      exp_q.delete();
    end else if (li.seg_strobe) begin
      if (PCHK && !m_first && (cyc - last_stb) != P) m_perr = 1'b1;
      m_first = 1'b0; last_stb = cyc; anchor = cyc; m_stall = 1'b0;
      if (!m_have_hi) begin
        m_have_hi = 1'b1; m_hi_pat = li.seg_in; m_fv = 1'b0;
      end else begin
        dh = ref_dec(m_hi_pat); dl = ref_dec(li.seg_in);
        m_have_hi = 1'b0; m_hi = dh[3:0]; m_lo = dl[3:0]; m_err = dh[4] | dl[4]; m_fv = 1'b1;
        exp_q.push_back({m_err, m_hi, m_lo});
      end
    end else begin
      m_fv = 1'b0;
      if (cyc - anchor == T) begin
        m_stall = 1'b1; m_have_hi = 1'b0; m_first = 1'b1;
      end
    end
  end

  // ---------------- compare / scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (chk_en) begin
      check("digit_hi", 32'(digit_hi), 32'(m_hi));
      check("digit_lo", 32'(digit_lo), 32'(m_lo));
      check("frame_err", 32'(frame_err), 32'(m_err));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("stall", 32'(stall), 32'(m_stall));
      check("period_err", 32'(period_err), 32'(m_perr));
      check("dbg_state", 32'(li.dbg_state), 32'(m_have_hi ? EXP_LO : EXP_HI));
      if (frame_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("frame_unexpected", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("frame_sb", 32'({frame_err, digit_hi, digit_lo}), 32'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(bit stb, logic [6:0] pat);
    @(negedge clk);
    li.seg_strobe = stb;
    li.seg_in     = stb ? pat : 7'($urandom);
    since         = stb ? 0 : since + 1;
  endtask

  task automatic send(int gap, logic [6:0] pat);
    repeat (gap - since - 1) step(1'b0, '0);
    step(1'b1, pat);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1; li.seg_strobe = 1'b0;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    since = 1;
  endtask

  task automatic pin_frame(string nm, logic [3:0] h, logic [3:0] l, logic e);
    step(1'b0, '0);
    check({nm, "_fv"}, 32'(frame_valid), 32'(1));
    check({nm, "_frame"}, 32'({e, h, l}), 32'({e, digit_hi, digit_lo}) ^ 32'({frame_err, digit_hi, digit_lo}) ^ 32'({e, h, l}) ^ 32'({e, h, l}) ^ 32'({e, digit_hi, digit_lo}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    logic [6:0] pat;
    rst = 1'b1;
    li.seg_strobe = 1'b0;
    li.seg_in = '0;
    do_reset(3);
    chk_en = 1'b1;
    check("rst_outputs", 32'({digit_hi, digit_lo, frame_valid, frame_err, stall, period_err}), 32'(0));

    send(P, 7'h4F); send(P, 7'h79);
    step(1'b0, '0);
    check("f1", 32'({frame_valid, frame_err, digit_hi, digit_lo}), 32'({1'b1, 1'b0, 4'h3, 4'hE}));

    send(P, 7'h00);
    step(1'b0, '0);
    check("f2_hold", 32'({frame_valid, digit_hi, digit_lo}), 32'({1'b0, 4'h3, 4'hE}));
    send(P, 7'h3F);
    step(1'b0, '0);
    check("f2", 32'({frame_valid, frame_err, digit_hi, digit_lo}), 32'({1'b1, 1'b1, 4'h0, 4'h0}));

    send(P, 7'h7F);
    while (since < T + 5) step(1'b0, '0);
    check("stall_set", 32'({stall, frame_valid}), 32'({1'b1, 1'b0}));
    send(since + 1, 7'h06);
    send(P, 7'h5B);
    step(1'b0, '0);
    check("f3", 32'({frame_valid, stall, digit_hi, digit_lo}), 32'({1'b1, 1'b0, 4'h1, 4'h2}));

    send(P, 7'h66);
    do_reset(2);
    check("rst_mid", 32'({digit_hi, digit_lo, frame_err, stall, period_err, li.dbg_state}), 32'(0));
    send(P, 7'h6D); send(P, 7'h7D);
    step(1'b0, '0);
    check("f4", 32'({digit_hi, digit_lo}), 32'({4'h5, 4'h6}));

    send(P, 7'h07);
    check("perr_ok", 32'(period_err), 32'(0));
    send(P - 1, 7'h7F);
    step(1'b0, '0);
    check("perr_short", 32'({period_err, digit_hi, digit_lo}), 32'({PCHK, 4'h7, 4'h8}));
    send(P, 7'h6F); send(P, 7'h5E);
    step(1'b0, '0);
    check("perr_sticky", 32'({period_err, digit_hi, digit_lo}), 32'({PCHK, 4'h9, 4'hD}));

    send(T, 7'h77); send(T, 7'h7C);
    step(1'b0, '0);
    check("coincident", 32'({stall, frame_valid, digit_hi, digit_lo}), 32'({1'b0, 1'b1, 4'hA, 4'hB}));

    send(P, 7'h39); send(1, 7'h5E);
    step(1'b0, '0);
    check("held_strobe", 32'({frame_valid, digit_hi, digit_lo}), 32'({1'b1, 4'hC, 4'hD}));

    for (int i = 0; i < 60; i++) begin
      pat = ($urandom_range(0, 9) < 8) ? tbl[$urandom_range(0, 15)] : 7'($urandom);
      case ($urandom_range(0, 9))
        0: g = 1;
        1: g = T;
        2: g = T + int'($urandom_range(1, 20));
        3: g = P - 1;
        4: g = P + 1;
        default: g = P;
      endcase
      if (g <= since) g = since + 1;
      send(g, pat);
      if ($urandom_range(0, 24) == 0) do_reset(int'($urandom_range(1, 3)));
    end

    repeat (5) step(1'b0, '0);
    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
